// File: rtl/y_collector_if.sv
// Producer-to-collector result stream: signed data with a valid/ready handshake.
interface y_collector_if #(
    parameter int unsigned WIDTH = 20
);
    logic signed [WIDTH-1:0] y_data;
    logic                    y_valid;
    logic                    y_ready;

    modport master (output y_data, output y_valid, input y_ready);
    modport slave  (input y_data, input y_valid, output y_ready);
endinterface

// File: rtl/y_collector.sv
// Stores one frame of convolution results, tracks running sum and signed max,
// and serves the stored frame through a one-cycle registered read port.
module y_collector #(
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned Y_LEN_IN  = 64,
    localparam int unsigned LOGY      = $clog2(Y_LEN_IN),
    localparam int unsigned SUM_WIDTH = WIDTH + LOGY
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    y_collector_if.slave                y,
    input  logic                        rd_en,
    input  logic [LOGY-1:0]             rd_addr,
    output logic signed [WIDTH-1:0]     rd_data,
    output logic                        rd_valid,
    output logic                        frame_done,
    output logic [LOGY:0]               y_count,
    output logic signed [WIDTH-1:0]     max_val,
    output logic signed [SUM_WIDTH-1:0] sum
);
    localparam int unsigned   MEM_DEPTH = 2 ** LOGY;
    localparam logic [LOGY:0] LAST_IDX  = (LOGY + 1)'(Y_LEN_IN - 1);
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   clear_c;
    logic   xfer_c;
    logic   rd_fire_c;

    logic signed [WIDTH-1:0] mem [MEM_DEPTH];

    assign y.y_ready  = (state_q == COLLECT);
    assign frame_done = (state_q == DONE);
    assign xfer_c     = y.y_valid && (state_q == COLLECT);

    // Next-state decode; start clears accumulators from IDLE or DONE and wins over a read
    always_comb begin
        state_d   = state_q;
        clear_c   = 1'b0;
        rd_fire_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    clear_c = 1'b1;
                end
            end
            COLLECT: begin
                if (xfer_c && (y_count == LAST_IDX)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = COLLECT;
                    clear_c = 1'b1;
                end else begin
                    rd_fire_c = rd_en;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_count  <= '0;
            sum      <= '0;
            max_val  <= MIN_VAL;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire_c;
            if (rd_fire_c) begin
                rd_data <= mem[rd_addr];
            end
            if (clear_c) begin
                y_count <= '0;
                sum     <= '0;
                max_val <= MIN_VAL;
            end else if (xfer_c) begin
                y_count <= y_count + (LOGY + 1)'(1);
                sum     <= sum + $signed({{LOGY{y.y_data[WIDTH-1]}}, y.y_data});
                if (y.y_data > max_val) begin
                    max_val <= y.y_data;
                end
            end
        end
    end

    // Result storage is deliberately never cleared; y_count bounds valid entries
    always_ff @(posedge clk) begin
        if (xfer_c) begin
            mem[y_count[LOGY-1:0]] <= y.y_data;
        end
    end

endmodule
